// File: rtl/collision_rom_arbiter.sv
// -----------------------------------------------------------------------------
// collision_rom_arbiter
//
// Purpose:
//   Shares the single read port of the full-screen collision ROM among
//   N_REQ requesters.
//   - A round-robin arbiter accepts at most one read per cycle.
//   - A fixed-latency tag pipeline follows each read through the ROM and
//     returns the result to the requester that issued it.
//   - Addresses outside the map are never sent to the ROM. They respond
//     with data 0 and the out-of-range flag set.
//
// Ports:
//   vga_clk        clock, all state updates on the rising edge
//   Reset          synchronous active-high reset
//   req            per-requester read request (valid)
//   req_addr       packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   hold           blocks new transfers while high; in-flight reads complete
//   gnt            combinational one-hot ready; transfer on req[i] & gnt[i]
//   rom_address_c  registered ROM address
//   rom_c          ROM read data, sampled ROM_LAT cycles after the address
//   rsp_valid      registered one-hot response pulse
//   rsp_data       registered response data (0 for out-of-range reads)
//   rsp_oob        registered out-of-range flag, qualified by rsp_valid
//   busy           high while any read is in the tag pipeline
// -----------------------------------------------------------------------------
module collision_rom_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 3,
  parameter int ROM_LAT  = 3,
  parameter int MAP_SIZE = 307200
) (
  input  logic                      vga_clk,
  input  logic                      Reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic                      hold,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         rom_address_c,
  input  logic [DATA_W-1:0]         rom_c,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_oob,
  output logic                      busy
);

  localparam int                ID_W    = $clog2(N_REQ);
  localparam int                LAST    = ROM_LAT - 1;
  // One extra bit so that a MAP_SIZE equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   MAP_LIM = (ADDR_W + 1)'(MAP_SIZE);
  localparam logic [N_REQ-1:0]  ONE_HOT = N_REQ'(1);

  logic [ID_W-1:0]   r_ptr;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ROM_LAT-1:0] r_tag_v;
  logic [ROM_LAT-1:0] r_tag_oob;
  logic [ID_W-1:0]   r_tag_id [ROM_LAT];
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_oob;

  logic [N_REQ-1:0]  w_mask;
  logic [N_REQ-1:0]  w_req_hi;
  logic [N_REQ-1:0]  w_pick;
  logic [N_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_ptr_next;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_xfer;
  logic              w_oob;

  // Round-robin arbitration uses a two-pass search.
  // - First pass: only requesters at or above the pointer are eligible.
  // - Second pass: if none of those is requesting, the search wraps to the
  //   lowest requesting index.
  // x & -x isolates the lowest set bit of x.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign w_mask[gi] = (ID_W'(gi) >= r_ptr);
    end
  endgenerate

  assign w_req_hi = req & w_mask;
  assign w_pick   = (|w_req_hi) ? (w_req_hi & (-w_req_hi)) : (req & (-req));
  assign w_gnt    = (Reset || hold) ? '0 : w_pick;
  assign gnt      = w_gnt;
  assign w_xfer   = |w_gnt;

  // Encode the one-hot winner and select its address.
  always_comb begin
    w_win      = '0;
    w_sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) begin
        w_win      = ID_W'(i);
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_oob      = ({1'b0, w_sel_addr} >= MAP_LIM);
  assign w_ptr_next = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;

  // Issue stage and tag pipeline. Every stage shifts every cycle, so the
  // last stage lines up with the ROM data for the address issued
  // ROM_LAT cycles earlier.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_ptr      <= '0;
      r_rom_addr <= '0;
      r_tag_v    <= '0;
      r_tag_oob  <= '0;
      for (int s = 0; s < ROM_LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_v[0] <= w_xfer;
      if (w_xfer) begin
        r_ptr        <= w_ptr_next;
        r_rom_addr   <= w_oob ? '0 : w_sel_addr;
        r_tag_id[0]  <= w_win;
        r_tag_oob[0] <= w_oob;
      end
      for (int s = 1; s < ROM_LAT; s++) begin
        r_tag_v[s]   <= r_tag_v[s-1];
        r_tag_oob[s] <= r_tag_oob[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  // Response stage. Data and oob keep their last values between responses.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_oob   <= 1'b0;
    end else if (r_tag_v[LAST]) begin
      r_rsp_valid <= ONE_HOT << r_tag_id[LAST];
      r_rsp_data  <= r_tag_oob[LAST] ? '0 : rom_c;
      r_rsp_oob   <= r_tag_oob[LAST];
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign rom_address_c = r_rom_addr;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_oob       = r_rsp_oob;
  assign busy          = |r_tag_v;

endmodule

// File: tb/tb_collision_rom_arbiter.sv
module tb_collision_rom_arbiter;

  localparam int N   = 4;
  localparam int AW  = 19;
  localparam int DW  = 3;
  localparam int LAT = 3;
  localparam int MAP = 307200;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic            hold;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_address_c;
  logic [DW-1:0]   rom_c;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_oob;
  logic            busy;

  always #5 clk = ~clk;

  collision_rom_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .MAP_SIZE(MAP)
  ) dut (
    .vga_clk(clk), .Reset(rst), .req(req), .req_addr(req_addr), .hold(hold),
    .gnt(gnt), .rom_address_c(rom_address_c), .rom_c(rom_c),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_oob(rsp_oob), .busy(busy)
  );

  // ROM contents as a function of address.
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    if (a == 19'd1000) return 3'd5;
    return a[2:0] ^ a[5:3] ^ a[18:16];
  endfunction

  // ROM model: the address is registered twice, so the data for an address
  // issued at edge k is present when edge k+3 samples it.
  logic [AW-1:0] a1, a2;
  always @(posedge clk) begin
    a1 <= rom_address_c;
    a2 <= a1;
  end
  assign rom_c = rom_fn(a2);

  // Reference model state
  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic          oob;
    int            due;
  } rd_t;

  rd_t           q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            m_ptr    = 0;
  logic [AW-1:0] m_addr   = '0;
  logic [N-1:0]  m_rv     = '0;
  logic [DW-1:0] m_rd     = '0;
  logic          m_ro     = 1'b0;
  logic [AW-1:0] addr_v [N];
  int            last_win;
  logic [N-1:0]  pend;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle, using the inputs the caller set beforehand.
  task automatic cycle();
    int           win;
    logic [N-1:0] eg;
    rd_t          e;

    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_v[i];

    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    check("rsp_data", 64'(rsp_data), 64'(m_rd));
    check("rsp_oob", 64'(rsp_oob), 64'(m_ro));
    check("busy", 64'(busy), 64'(q.size() != 0));
    check("rom_addr", 64'(rom_address_c), 64'(m_addr));

    #1;
    win = -1;
    if (!rst && !hold) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (req[i]) begin
          win = i;
          break;
        end
      end
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    check("gnt", 64'(gnt), 64'(eg));

    @(posedge clk);
    cyc++;
    last_win = -1;
    if (rst) begin
      q.delete();
      m_rv   = '0;
      m_rd   = '0;
      m_ro   = 1'b0;
      m_ptr  = 0;
      m_addr = '0;
    end else begin
      if (q.size() != 0 && q[0].due == cyc) begin
        e        = q.pop_front();
        m_rv     = '0;
        m_rv[e.id] = 1'b1;
        m_rd     = e.oob ? '0 : rom_fn(e.addr);
        m_ro     = e.oob;
      end else begin
        m_rv = '0;
      end
      if (win >= 0) begin
        e.id   = win;
        e.oob  = (int'(addr_v[win]) >= MAP);
        e.addr = e.oob ? '0 : addr_v[win];
        e.due  = cyc + LAT;
        q.push_back(e);
        m_addr   = e.addr;
        m_ptr    = (win + 1) % N;
        last_win = win;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return AW'(MAP - 1);
      1:       return AW'(MAP);
      2:       return AW'($urandom_range(MAP, (1 << AW) - 1));
      default: return AW'($urandom_range(0, MAP - 1));
    endcase
  endfunction

  initial begin
    rst  = 1'b1;
    req  = '0;
    hold = 1'b0;
    pend = '0;
    for (int i = 0; i < N; i++) addr_v[i] = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = '0;
    @(posedge clk);
    #1;
    idle(2);
    rst = 1'b0;

    // Single read: requester 2, address 1000, data 5
    addr_v[2] = 19'd1000;
    req = 4'b0100;
    cycle();
    req = '0;
    idle(4);

    // All four requesting with distinct addresses
    addr_v[0] = 19'd10;
    addr_v[1] = 19'd20;
    addr_v[2] = 19'd30;
    addr_v[3] = 19'd40;
    req = 4'b1111;
    idle(8);

    // Pointer wrap and skip of idle requesters
    req = 4'b0101;
    idle(3);
    req = '0;
    idle(4);

    // Out-of-range address, then the last valid address
    addr_v[1] = 19'd307200;
    req = 4'b0010;
    cycle();
    addr_v[1] = 19'd307199;
    cycle();
    req = '0;
    idle(4);

    // hold with reads in flight and requests pending
    req = 4'b1111;
    idle(2);
    hold = 1'b1;
    idle(4);
    hold = 1'b0;
    idle(2);
    req = '0;
    idle(4);

    // Reset while three reads are in flight
    req = 4'b0111;
    idle(3);
    req = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle(4);
    req = 4'b0110;
    cycle();
    req = '0;
    idle(4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          addr_v[i] = rand_addr();
        end
      end
      req  = pend;
      hold = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 149) == 0);
      cycle();
      if (last_win >= 0) pend[last_win] = 1'b0;
    end
    rst  = 1'b0;
    hold = 1'b0;
    req  = '0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
